bnn_act_accum_cfu: RTL and testbench
====================================

# bnn_act_accum_cfu

Sequential BNN activation stage that sits directly downstream of the 32-bit combinational XNOR-popcount dot-product CFU. It accumulates per-chunk popcounts of weight/activation words into a neuron sum. It then thresholds the sum into a 1-bit activation and packs successive activations into a 32-bit word that feeds the next layer. It is a multi-cycle CFU with a valid/ready request/response handshake and one request in flight.

## Interface
- CFU_FUNC_ID_W, 2: function-id width.
- CFU_REQ_DATA_W, 32: request operand width; only 32 is supported.
- CFU_RESP_DATA_W, 32: response width.
- ACC_W, 16: width of the accumulator and of the threshold.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_func_id  in  CFU_FUNC_ID_W  0=ACCUM, 1=SET_THRESH, 2=ACTIVATE, 3=DRAIN.
- req_data0  in  CFU_REQ_DATA_W  weights, or threshold for SET_THRESH.
- req_data1  in  CFU_REQ_DATA_W  activations.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid and resp_ready are both high.
- resp_data  out  CFU_RESP_DATA_W  result.
- act_full  out  1  packer holds 32 unread activation bits.

## Operation
- State registers:
  - acc[ACC_W]
  - thresh[ACC_W]
  - pack[32]
  - cnt[6], range 0..32
  - captured request: func, d0, d1
  - pc[6]
- FSM states: IDLE, POP, RESP.
- IDLE:
  - req_ready=1.
  - On accept, capture the request and go to POP.
- POP:
  - req_ready=0.
  - Register pc = popcount(d0 ~^ d1), then go to RESP.
  - In the same edge, execute the function, load resp_data and set resp_valid.
- RESP:
  - resp_valid=1; resp_data is held stable until the handshake.
  - req_ready = resp_ready.
  - On resp_ready with a simultaneous accept: go to POP with the new request.
  - On resp_ready alone: go to IDLE.
- Functions (all results zero-extended to 32 bits):
  - ACCUM: acc ← acc + pc; resp = new acc.
  - SET_THRESH: thresh ← d0[ACC_W-1:0]; resp = old thresh.
  - ACTIVATE: b = (acc >= thresh), unsigned compare. pack ← {pack[30:0], b}; cnt ← min(cnt+1, 32); acc ← 0; resp = new pack.
  - DRAIN: resp = pack; then pack ← 0 and cnt ← 0.
- Arithmetic and boundaries:
  - pc is in 0..32; the accumulator adds pc zero-extended to ACC_W.
  - ACTIVATE when cnt==32: the oldest bit shifts out, cnt stays 32, act_full stays 1.
  - act_full = (cnt==32), registered. It clears on a DRAIN response.
  - ACTIVATE with acc==thresh yields b=1.
- Reset values:
  - state IDLE, acc=0, thresh=0, pack=0, cnt=0, pc=0.
  - resp_valid=0, resp_data=0, act_full=0.
  - req_ready=1 (decoded from IDLE); no accept occurs while rst_n is low.
- Reset mid-operation: the in-flight request is discarded and no response is produced. All state returns to reset values immediately (asynchronous).

## Timing
- An accept at edge t loads POP; resp_valid rises after edge t+1, giving 2-cycle latency.
- Peak throughput is 1 request per 2 cycles (pipelined accept in RESP with resp_ready=1).
- req_ready depends combinationally on state and resp_ready only. No path exists from req_valid to req_ready.
- resp_data, resp_valid and act_full are registered outputs.

## Configuration
- BNN_ACCUM_SAT_EN defined: ACCUM saturates at 2^ACC_W−1.
- BNN_ACCUM_SAT_EN undefined: ACCUM wraps modulo 2^ACC_W.

## Structure
- Shared package holds:
  - function-id constants FN_ACCUM, FN_SET_THRESH, FN_ACTIVATE, FN_DRAIN;
  - the FSM state enum;
  - the packer width constant 32.
- One sub-module: bnn_popcount_xnor32 (combinational XNOR + 32-bit popcount → 6 bits), instantiated once in POP.
- The top contains the FSM, accumulator, threshold and packer.

## Test plan
- Reset, then ACCUM d0=0x0000FFFF, d1=0x0000FFFF → resp_data=32 exactly 2 cycles after accept; ACCUM d0=0xFFFFFFFF, d1=0 → resp_data=32 (pc=0).
- SET_THRESH d0=20 → resp 0. ACCUM d0=0xFFFF0000, d1=0 (pc=16) then ACTIVATE → resp 0x0. ACCUM pc=32 then ACTIVATE → resp 0x1; acc reads back 0 on the next ACCUM with pc=0.
- thresh=0, 33 × ACTIVATE → resp 0xFFFFFFFF; act_full=1 after the 32nd and still 1 after the 33rd. DRAIN → 0xFFFFFFFF and act_full=0; second DRAIN → 0.
- 2047 × ACCUM(pc=32) → acc=0xFFE0. Next ACCUM → 0x0000 without BNN_ACCUM_SAT_EN, 0xFFFF with it.
- Hold resp_ready=0 for 5 cycles with req_valid=1 → resp_valid=1 and resp_data stable, req_ready=0. Raise resp_ready → next request accepted the same edge, its response 2 cycles later.
- Assert rst_n=0 during POP → resp_valid=0 and acc/pack/cnt=0 immediately. After release, the first response belongs to the next accepted request.

Source files
------------

// File: rtl/bnn_act_accum_cfu_pkg.sv
// Shared constants for the BNN activation/accumulate CFU: function ids,
// FSM state encoding and packer geometry.
package bnn_act_accum_cfu_pkg;

  localparam logic [1:0] FN_ACCUM      = 2'd0;
  localparam logic [1:0] FN_SET_THRESH = 2'd1;
  localparam logic [1:0] FN_ACTIVATE   = 2'd2;
  localparam logic [1:0] FN_DRAIN      = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_POP  = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam int         PACK_W   = 32;
  localparam logic [5:0] CNT_FULL = 6'd32;

endpackage

// File: rtl/bnn_popcount_xnor32.sv
// Combinational XNOR of two 32-bit words followed by a popcount (0..32).
module bnn_popcount_xnor32 (
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  output logic [5:0]  pc
);

  logic [31:0] match;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_xnor
      assign match[gi] = ~(d0[gi] ^ d1[gi]);
    end
  endgenerate

  always_comb begin
    pc = '0;
    for (int i = 0; i < 32; i++) pc = pc + {5'b0, match[i]};
  end

endmodule

// File: rtl/bnn_act_accum_cfu.sv
// BNN activation CFU: accumulates XNOR-popcounts, thresholds into 1-bit
// activations and packs them. Define BNN_ACCUM_SAT_EN for a saturating ACCUM.
module bnn_act_accum_cfu
  import bnn_act_accum_cfu_pkg::*;
#(
  parameter int CFU_FUNC_ID_W   = 2,
  parameter int CFU_REQ_DATA_W  = 32,
  parameter int CFU_RESP_DATA_W = 32,
  parameter int ACC_W           = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [CFU_FUNC_ID_W-1:0]   req_func_id,
  input  logic [CFU_REQ_DATA_W-1:0]  req_data0,
  input  logic [CFU_REQ_DATA_W-1:0]  req_data1,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [CFU_RESP_DATA_W-1:0] resp_data,
  output logic                       act_full
);

  state_t                      state_reg;
  logic [CFU_FUNC_ID_W-1:0]    func_reg;
  logic [CFU_REQ_DATA_W-1:0]   d0_reg, d1_reg;
  logic [ACC_W-1:0]            acc_reg, thresh_reg;
  logic [PACK_W-1:0]           pack_reg;
  logic [5:0]                  cnt_reg, pc_reg;

  logic [5:0]                  pc_comb;
  logic [ACC_W-1:0]            acc_add;
  logic [ACC_W-1:0]            acc_next, thresh_next;
  logic [PACK_W-1:0]           pack_next;
  logic [5:0]                  cnt_next;
  logic [CFU_RESP_DATA_W-1:0]  resp_next;
  logic                        accept;
  logic                        act_bit;

  assign req_ready = (state_reg == ST_IDLE) || ((state_reg == ST_RESP) && resp_ready);
  assign accept    = req_valid && req_ready;

  bnn_popcount_xnor32 u_pop (
    .d0 (d0_reg),
    .d1 (d1_reg),
    .pc (pc_comb)
  );

`ifdef BNN_ACCUM_SAT_EN
  logic [ACC_W:0] acc_sum;
  assign acc_sum = {1'b0, acc_reg} + (ACC_W+1)'(pc_comb);
  assign acc_add = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`else
  assign acc_add = acc_reg + ACC_W'(pc_comb);
`endif

  assign act_bit = (acc_reg >= thresh_reg);

  // Function results, committed on the POP edge.
  always_comb begin
    acc_next    = acc_reg;
    thresh_next = thresh_reg;
    pack_next   = pack_reg;
    cnt_next    = cnt_reg;
    resp_next   = '0;
    case (func_reg)
      FN_ACCUM: begin
        acc_next  = acc_add;
        resp_next = CFU_RESP_DATA_W'(acc_add);
      end
      FN_SET_THRESH: begin
        thresh_next = d0_reg[ACC_W-1:0];
        resp_next   = CFU_RESP_DATA_W'(thresh_reg);
      end
      FN_ACTIVATE: begin
        pack_next = {pack_reg[PACK_W-2:0], act_bit};
        cnt_next  = (cnt_reg == CNT_FULL) ? CNT_FULL : cnt_reg + 6'd1;
        acc_next  = '0;
        resp_next = CFU_RESP_DATA_W'(pack_next);
      end
      default: begin
        resp_next = CFU_RESP_DATA_W'(pack_reg);
        pack_next = '0;
        cnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      func_reg   <= '0;
      d0_reg     <= '0;
      d1_reg     <= '0;
      acc_reg    <= '0;
      thresh_reg <= '0;
      pack_reg   <= '0;
      cnt_reg    <= '0;
      pc_reg     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      act_full   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            func_reg  <= req_func_id;
            d0_reg    <= req_data0;
            d1_reg    <= req_data1;
            state_reg <= ST_POP;
          end
        end
        ST_POP: begin
          pc_reg     <= pc_comb;
          acc_reg    <= acc_next;
          thresh_reg <= thresh_next;
          pack_reg   <= pack_next;
          cnt_reg    <= cnt_next;
          resp_data  <= resp_next;
          resp_valid <= 1'b1;
          act_full   <= (cnt_next == CNT_FULL);
          state_reg  <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (accept) begin
              func_reg  <= req_func_id;
              d0_reg    <= req_data0;
              d1_reg    <= req_data1;
              state_reg <= ST_POP;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // The popcount of the last executed request is kept for visibility only.
  logic pc_seen;
  assign pc_seen = ^pc_reg;
  logic unused_ok;
  assign unused_ok = pc_seen & 1'b0;

endmodule

// File: tb/tb_bnn_act_accum_cfu.sv
// Self-checking bench for bnn_act_accum_cfu: directed table, multi-cycle
// corner sequences and randomized traffic against a behavioural model.
module tb_bnn_act_accum_cfu;
  import bnn_act_accum_cfu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_func_id = 2'd0;
  logic [31:0] req_data0 = '0, req_data1 = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        act_full;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  // Behavioural model state
  int          m_acc, m_thresh, m_cnt;
  logic [31:0] m_pack;

  always #5 clk = ~clk;

  bnn_act_accum_cfu dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_func_id(req_func_id), .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .act_full(act_full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int pc;
    pc = $countones(~(a ^ b));
    r = '0;
    case (f)
      FN_ACCUM: begin
        m_acc = m_acc + pc;
`ifdef BNN_ACCUM_SAT_EN
        if (m_acc > 65535) m_acc = 65535;
`else
        m_acc = m_acc % 65536;
`endif
        r = m_acc;
      end
      FN_SET_THRESH: begin
        r = m_thresh;
        m_thresh = int'(a[15:0]);
      end
      FN_ACTIVATE: begin
        m_pack = {m_pack[30:0], (m_acc >= m_thresh) ? 1'b1 : 1'b0};
        if (m_cnt < 32) m_cnt = m_cnt + 1;
        m_acc = 0;
        r = m_pack;
      end
      default: begin
        r = m_pack;
        m_pack = '0;
        m_cnt = 0;
      end
    endcase
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_acc = 0; m_thresh = 0; m_cnt = 0; m_pack = '0;
  endtask

  task automatic xact(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                      input int stall, output logic [31:0] r, output logic full, output int lat);
    int n;
    r = '0; full = 1'b0; lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_func_id = f; req_data0 = a; req_data1 = b;
    resp_ready = (stall == 0);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) chk("resp_timeout", {31'b0, resp_valid}, 32'd1);
    r = resp_data; full = act_full;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_data", resp_data, r);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_release", {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input int stall,
                    output logic [31:0] r, output logic full, output int lat,
                    output logic [31:0] exp_r, output logic exp_full);
    xact(f, a, b, stall, r, full, lat);
    exp_r = model(f, a, b);
    exp_full = (m_cnt == 32);
    if (verbose)
      $display("xact func=%0d d0=%h d1=%h resp=%h exp=%h full=%0b lat=%0d", f, a, b, r, exp_r, full, lat);
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  f;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] exp_resp;
    logic        exp_full;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] r, er, exp1, exp2;
    logic        full, ef;
    int          lat;

    tbl[0] = '{1'b1, FN_ACCUM,      32'h0000FFFF, 32'h0000FFFF, 32'd32, 1'b0};
    tbl[1] = '{1'b0, FN_ACCUM,      32'hFFFFFFFF, 32'h00000000, 32'd32, 1'b0};
    tbl[2] = '{1'b1, FN_SET_THRESH, 32'd20,       32'h00000000, 32'd0,  1'b0};
    tbl[3] = '{1'b0, FN_ACCUM,      32'hFFFF0000, 32'h00000000, 32'd16, 1'b0};
    tbl[4] = '{1'b0, FN_ACTIVATE,   32'h00000000, 32'h00000000, 32'h0,  1'b0};
    tbl[5] = '{1'b0, FN_ACCUM,      32'h00000000, 32'h00000000, 32'd32, 1'b0};
    tbl[6] = '{1'b0, FN_ACTIVATE,   32'h00000000, 32'h00000000, 32'h1,  1'b0};
    tbl[7] = '{1'b0, FN_ACCUM,      32'hFFFFFFFF, 32'h00000000, 32'd0,  1'b0};
    tbl[8] = '{1'b0, FN_SET_THRESH, 32'd0,        32'h00000000, 32'd20, 1'b0};
    tbl[9] = '{1'b0, FN_DRAIN,      32'h00000000, 32'h00000000, 32'h1,  1'b0};

    do_reset();
    #1;
    chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_data",  resp_data,           32'd0);
    chk("rst_act_full",   {31'b0, act_full},   32'd0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) do_reset();
      op(tbl[i].f, tbl[i].d0, tbl[i].d1, 0, r, full, lat, er, ef);
      chk($sformatf("tbl%0d_resp", i), r, tbl[i].exp_resp);
      chk($sformatf("tbl%0d_full", i), {31'b0, full}, {31'b0, tbl[i].exp_full});
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd2);
    end

    // Packer fill past 32 with thresh=0
    for (int i = 1; i <= 33; i++) begin
      op(FN_ACTIVATE, 32'h0, 32'h0, 0, r, full, lat, er, ef);
      chk($sformatf("act%0d_resp", i), r, (i >= 32) ? 32'hFFFFFFFF : ((32'd1 << i) - 32'd1));
      chk($sformatf("act%0d_full", i), {31'b0, full}, (i >= 32) ? 32'd1 : 32'd0);
    end
    op(FN_DRAIN, 32'h0, 32'h0, 0, r, full, lat, er, ef);
    chk("drain1_resp", r, 32'hFFFFFFFF);
    chk("drain1_full", {31'b0, full}, 32'd0);
    op(FN_DRAIN, 32'h0, 32'h0, 0, r, full, lat, er, ef);
    chk("drain2_resp", r, 32'h0);

    // Accumulator wrap / saturation boundary
    verbose = 1'b0;
    for (int i = 0; i < 2047; i++) op(FN_ACCUM, 32'h0, 32'h0, 0, r, full, lat, er, ef);
    verbose = 1'b1;
    chk("acc_ffe0", r, 32'h0000FFE0);
    op(FN_ACCUM, 32'h0, 32'h0, 0, r, full, lat, er, ef);
`ifdef BNN_ACCUM_SAT_EN
    chk("acc_over", r, 32'h0000FFFF);
`else
    chk("acc_over", r, 32'h00000000);
`endif
    op(FN_ACTIVATE, 32'h0, 32'h0, 0, r, full, lat, er, ef);
    chk("act_after_over", r, er);

    // Backpressure with a pending request, then pipelined accept
    @(negedge clk);
    req_valid = 1'b1; req_func_id = FN_ACCUM; req_data0 = 32'h0; req_data1 = 32'h0;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    exp1 = model(FN_ACCUM, 32'h0, 32'h0);
    req_data0 = 32'h0F0F0F0F;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", i), {31'b0, resp_valid}, 32'd1);
      chk($sformatf("stall%0d_data", i), resp_data, exp1);
      chk($sformatf("stall%0d_ready", i), {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    chk("stall_release_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("pipe_pop_valid", {31'b0, resp_valid}, 32'd0);
    req_valid = 1'b0;
    exp2 = model(FN_ACCUM, 32'h0F0F0F0F, 32'h0);
    @(posedge clk); #1;
    chk("pipe_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("pipe_resp_data", resp_data, exp2);
    $display("xact pipelined resp1=%h resp2=%h", exp1, resp_data);
    @(posedge clk); #1;
    resp_ready = 1'b0;

    // Reset asserted while a request sits in POP
    op(FN_ACTIVATE, 32'h0, 32'h0, 0, r, full, lat, er, ef);
    op(FN_ACCUM, 32'h0, 32'h0, 0, r, full, lat, er, ef);
    @(negedge clk);
    req_valid = 1'b1; req_func_id = FN_ACCUM; req_data0 = 32'h0; req_data1 = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("mid_rst_acc",   32'(dut.acc_reg),    32'd0);
    chk("mid_rst_pack",  dut.pack_reg,        32'd0);
    chk("mid_rst_cnt",   32'(dut.cnt_reg),    32'd0);
    chk("mid_rst_full",  {31'b0, act_full},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = 0; m_thresh = 0; m_cnt = 0; m_pack = '0;
    @(posedge clk); #1;
    chk("post_rst_no_resp", {31'b0, resp_valid}, 32'd0);
    op(FN_ACCUM, 32'h0000FFFF, 32'h0, 0, r, full, lat, er, ef);
    chk("post_rst_first", r, 32'd16);

    // Randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  f;
      logic [31:0] a, b;
      f = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? (a ^ ($urandom & $urandom & $urandom)) : $urandom;
      if (f == FN_SET_THRESH) a = 32'($urandom_range(0, 120));
      op(f, a, b, $urandom_range(0, 2), r, full, lat, er, ef);
      chk($sformatf("rnd%0d_resp", i), r, er);
      chk($sformatf("rnd%0d_full", i), {31'b0, full}, {31'b0, ef});
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
